// File: rtl/rom_read_arbiter_if.sv
// Request/response bundle between the two ROM clients and rom_read_arbiter.
// master = client side, slave = arbiter side.
interface rom_read_arbiter_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [ADDR_WIDTH-1:0] req_addr0;
    logic [ADDR_WIDTH-1:0] req_addr1;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_id;

    modport master (
        output req_valid, req_addr0, req_addr1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_addr0, req_addr1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin sharing of one synchronous ROM macro between two read requesters;
// drives csb0/addr0, captures dout0 one cycle after issue, returns tagged data.
module rom_read_arbiter #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    rom_read_arbiter_if.slave     rif,
    output logic                  csb0,
    output logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  read_count
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  last_q;
    logic [1:0]            grant;
    logic                  grant_id;
    logic                  accept;
    logic                  rsp_hs;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_id_q;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        grant = '0;
        case (rif.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    assign grant_id      = grant[1];
    assign rif.req_ready = (state_q == IDLE) ? grant : 2'b00;
    assign accept        = |(rif.req_valid & rif.req_ready);
    assign rsp_hs        = rsp_valid_q & rif.rsp_ready;

    assign rif.rsp_valid = rsp_valid_q;
    assign rif.rsp_data  = rsp_data_q;
    assign rif.rsp_id    = rsp_id_q;
    assign busy          = (state_q != IDLE);

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // dout0 is only sampled in CAPTURE, so stale macro output after an abort is ignored.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            csb0        <= 1'b1;
            addr0       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            read_count  <= '0;
            last_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr0    <= grant_id ? rif.req_addr1 : rif.req_addr0;
                        rsp_id_q <= grant_id;
                        last_q   <= grant_id;
                        csb0     <= 1'b0;
                    end
                end
                ISSUE: begin
                    csb0 <= 1'b1;
                end
                CAPTURE: begin
                    rsp_data_q  <= dout0;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp_valid_q <= 1'b0;
                        if (read_count != '1) begin
                            read_count <= read_count + CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    csb0 <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a behavioural ROM (mem[i] = i ^ 8'hA5)
// plus a narrow-counter instance for the saturation check.
module tb_rom_read_arbiter;

    logic       clk0;
    logic       rst0_n;
    logic       csb0;
    logic [6:0] addr0;
    logic [7:0] dout0 = '0;
    logic       busy;
    logic [15:0] read_count;

    logic       rst_s_n;
    logic       s_csb0;
    logic [6:0] s_addr0;
    logic [7:0] s_dout0 = '0;
    logic       s_busy;
    logic [2:0] s_count;

    int tests = 0;
    int fails = 0;
    int csb_lows = 0;

    rom_read_arbiter_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) rif ();
    rom_read_arbiter_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) sif ();

    rom_read_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk0       (clk0),
        .rst0_n     (rst0_n),
        .rif        (rif),
        .csb0       (csb0),
        .addr0      (addr0),
        .dout0      (dout0),
        .busy       (busy),
        .read_count (read_count)
    );

    rom_read_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .CNT_WIDTH(3)) u_sat (
        .clk0       (clk0),
        .rst0_n     (rst_s_n),
        .rif        (sif),
        .csb0       (s_csb0),
        .addr0      (s_addr0),
        .dout0      (s_dout0),
        .busy       (s_busy),
        .read_count (s_count)
    );

    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    // Macro model: samples csb0/addr0 at posedge, drives dout0 at the following negedge.
    logic       rom_en = 1'b0;
    logic [6:0] rom_a  = '0;
    always @(posedge clk0) begin
        rom_en <= !csb0;
        rom_a  <= addr0;
    end
    always @(negedge clk0) begin
        if (rom_en) dout0 <= {1'b0, rom_a} ^ 8'hA5;
        if (csb0 === 1'b0) csb_lows++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    task automatic reset_pulse();
        rst0_n = 1'b0;
        #3;
        rst0_n = 1'b1;
    endtask

    initial begin
        rst0_n = 1'b0;
        rst_s_n = 1'b0;
        rif.req_valid = 2'b00;
        rif.req_addr0 = '0;
        rif.req_addr1 = '0;
        rif.rsp_ready = 1'b0;
        sif.req_valid = 2'b00;
        sif.req_addr0 = 7'h11;
        sif.req_addr1 = 7'h22;
        sif.rsp_ready = 1'b1;

        #12;
        check("rst_csb0", csb0, 1);
        check("rst_addr0", addr0, 0);
        check("rst_rsp_valid", rif.rsp_valid, 0);
        check("rst_rsp_data", rif.rsp_data, 0);
        check("rst_rsp_id", rif.rsp_id, 0);
        check("rst_count", read_count, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", rif.req_ready, 0);
        rst0_n = 1'b1;
        rst_s_n = 1'b1;

        // 1: single request from requester 0
        rif.req_valid = 2'b01;
        rif.req_addr0 = 7'h05;
        rif.rsp_ready = 1'b1;
        #1;
        check("t1_ready", rif.req_ready, 2'b01);
        step();
        check("t1_csb_low", csb0, 0);
        check("t1_addr0", addr0, 7'h05);
        check("t1_busy", busy, 1);
        check("t1_ready_busy", rif.req_ready, 0);
        rif.req_valid = 2'b00;
        step();
        check("t1_csb_high", csb0, 1);
        check("t1_no_valid_yet", rif.rsp_valid, 0);
        step();
        check("t1_rsp_valid", rif.rsp_valid, 1);
        check("t1_rsp_data", rif.rsp_data, 8'hA0);
        check("t1_rsp_id", rif.rsp_id, 0);
        step();
        check("t1_rsp_done", rif.rsp_valid, 0);
        check("t1_count", read_count, 1);
        check("t1_idle", busy, 0);

        // 2: both requesters continuously valid, fresh pointer
        reset_pulse();
        rif.req_valid = 2'b11;
        rif.req_addr0 = 7'h00;
        rif.req_addr1 = 7'h7F;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_ready", rif.req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
            step();
            check("t2_addr0", addr0, (i % 2 == 1) ? 7'h7F : 7'h00);
            check("t2_csb_low", csb0, 0);
            step();
            step();
            check("t2_rsp_valid", rif.rsp_valid, 1);
            check("t2_rsp_data", rif.rsp_data, (i % 2 == 1) ? 8'hDA : 8'hA5);
            check("t2_rsp_id", rif.rsp_id, i % 2);
            step();
            check("t2_rsp_done", rif.rsp_valid, 0);
        end
        check("t2_count", read_count, 4);

        // 3: response back-pressure with a request pending
        rif.req_valid = 2'b01;
        rif.req_addr0 = 7'h10;
        rif.rsp_ready = 1'b0;
        #1;
        check("t3_ready", rif.req_ready, 2'b01);
        step();
        rif.req_valid = 2'b11;
        rif.req_addr1 = 7'h22;
        #1;
        check("t3_ready_busy", rif.req_ready, 0);
        step();
        step();
        check("t3_rsp_valid", rif.rsp_valid, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("t3_hold_valid", rif.rsp_valid, 1);
            check("t3_hold_data", rif.rsp_data, 8'hB5);
            check("t3_hold_id", rif.rsp_id, 0);
            check("t3_hold_ready", rif.req_ready, 0);
            check("t3_hold_csb", csb0, 1);
        end
        rif.rsp_ready = 1'b1;
        step();
        check("t3_hs_done", rif.rsp_valid, 0);
        #1;
        check("t3_next_ready", rif.req_ready, 2'b10);
        step();
        check("t3_next_addr", addr0, 7'h22);
        check("t3_next_csb", csb0, 0);
        rif.req_valid = 2'b00;
        step();
        step();
        check("t3_next_data", rif.rsp_data, 8'h87);
        check("t3_next_id", rif.rsp_id, 1);
        step();
        check("t3_count", read_count, 6);

        // 4: reset asserted during ISSUE
        rif.req_valid = 2'b01;
        rif.req_addr0 = 7'h33;
        step();
        check("t4_issue_csb", csb0, 0);
        rif.req_valid = 2'b00;
        #2;
        rst0_n = 1'b0;
        #1;
        check("t4_rst_csb", csb0, 1);
        check("t4_rst_valid", rif.rsp_valid, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_addr", addr0, 0);
        check("t4_rst_count", read_count, 0);
        #1;
        rst0_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t4_no_rsp", rif.rsp_valid, 0);
            check("t4_no_csb", csb0, 1);
        end
        check("t4_count", read_count, 0);

        // 6: one-cycle pulse from requester 1 while busy
        rif.req_valid = 2'b01;
        rif.req_addr0 = 7'h01;
        #1;
        check("t6_ready", rif.req_ready, 2'b01);
        step();
        rif.req_valid = 2'b10;
        rif.req_addr1 = 7'h44;
        #1;
        check("t6_pulse_ready", rif.req_ready, 0);
        step();
        rif.req_valid = 2'b00;
        check("t6_csb", csb0, 1);
        check("t6_addr", addr0, 7'h01);
        step();
        check("t6_rsp_data", rif.rsp_data, 8'hA4);
        check("t6_rsp_id", rif.rsp_id, 0);
        step();
        check("t6_count", read_count, 1);
        check("t6_idle_csb", csb0, 1);
        step();
        check("t6_no_grant_csb", csb0, 1);
        check("t6_no_grant_busy", busy, 0);
        check("t6_addr_kept", addr0, 7'h01);

        check("csb_low_cycles", csb_lows, 8);

        // 5: saturation on the 3-bit counter instance (1 read per 4 cycles)
        sif.req_valid = 2'b01;
        for (int k = 0; k < 24; k++) step();
        check("t5_count6", s_count, 6);
        for (int k = 0; k < 4; k++) step();
        check("t5_count7", s_count, 7);
        for (int k = 0; k < 8; k++) step();
        check("t5_saturated", s_count, 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
